// File: rtl/walk_phase_ctrl.sv
// Pedestrian walk-phase sequencer: acks the walk latch, then WALK / FLASH / CLEAR.
// Optional WALK_COUNTDOWN_EN adds a registered Countdown output during FLASH.
module walk_phase_ctrl #(
   parameter int unsigned WALK_TIME  = 8,
   parameter int unsigned FLASH_TIME = 6,
   parameter int unsigned CLEAR_TIME = 2,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             Reset_n,
   input  logic             Tick,
   input  logic             WalkReq,
   input  logic             Ped_Window,
   output logic             WalkReg_Reset,
   output logic             Ped_Busy,
   output logic             Ped_Done,
   output logic             Walk_Lamp,
`ifdef WALK_COUNTDOWN_EN
   output logic             DontWalk_Lamp,
   output logic [CNT_W-1:0] Countdown
`else
   output logic             DontWalk_Lamp
`endif
);

   // zero-length phases are stretched to a single tick
   localparam logic [CNT_W-1:0] WALK_LD =
      (WALK_TIME == 0) ? CNT_W'(1) : CNT_W'(WALK_TIME);
   localparam logic [CNT_W-1:0] FLASH_LD =
      (FLASH_TIME == 0) ? CNT_W'(1) : CNT_W'(FLASH_TIME);
   localparam logic [CNT_W-1:0] CLEAR_LD =
      (CLEAR_TIME == 0) ? CNT_W'(1) : CNT_W'(CLEAR_TIME);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACK,
      S_WALK,
      S_FLASH,
      S_CLEAR
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             blink;
   logic             blink_nxt;
   logic             last_tick;

   logic             wrr_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             walk_nxt;
   logic             dw_nxt;
`ifdef WALK_COUNTDOWN_EN
   logic [CNT_W-1:0] cd_nxt;
`endif

   assign last_tick = Tick && (cnt == ONE);

   // state register
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: begin
            if (WalkReq && Ped_Window) state_nxt = S_ACK;
         end
         S_ACK: begin
            state_nxt = S_WALK;
         end
         S_WALK: begin
            if (last_tick) state_nxt = S_FLASH;
         end
         S_FLASH: begin
            if (last_tick) state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            if (last_tick) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // phase tick counter and blink phase, next values
   always_comb begin
      cnt_nxt   = cnt;
      blink_nxt = blink;
      unique case (state)
         S_IDLE: begin
            cnt_nxt   = '0;
            blink_nxt = 1'b0;
         end
         S_ACK: begin
            cnt_nxt = WALK_LD;
         end
         S_WALK: begin
            if (last_tick) begin
               cnt_nxt   = FLASH_LD;
               blink_nxt = 1'b0;
            end else if (Tick && cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end
         end
         S_FLASH: begin
            if (Tick) blink_nxt = ~blink;
            if (last_tick) begin
               cnt_nxt = CLEAR_LD;
            end else if (Tick && cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end
         end
         S_CLEAR: begin
            if (last_tick) begin
               cnt_nxt = '0;
            end else if (Tick && cnt != '0) begin
               cnt_nxt = cnt - ONE;
            end
         end
         default: begin
            cnt_nxt   = '0;
            blink_nxt = 1'b0;
         end
      endcase
   end

   // counter and blink registers
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cnt   <= '0;
         blink <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         blink <= blink_nxt;
      end
   end

   // output decode from the state being entered, so outputs line up with state
   always_comb begin
      wrr_nxt  = 1'b0;
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      walk_nxt = 1'b0;
      dw_nxt   = 1'b1;
`ifdef WALK_COUNTDOWN_EN
      cd_nxt   = '0;
`endif
      unique case (state_nxt)
         S_IDLE: begin
            done_nxt = (state == S_CLEAR);
         end
         S_ACK: begin
            wrr_nxt  = 1'b1;
            busy_nxt = 1'b1;
         end
         S_WALK: begin
            busy_nxt = 1'b1;
            walk_nxt = 1'b1;
            dw_nxt   = 1'b0;
         end
         S_FLASH: begin
            busy_nxt = 1'b1;
            dw_nxt   = ~blink_nxt;
`ifdef WALK_COUNTDOWN_EN
            cd_nxt   = cnt_nxt;
`endif
         end
         S_CLEAR: begin
            busy_nxt = 1'b1;
         end
         default: begin
            busy_nxt = 1'b0;
         end
      endcase
   end

   // registered outputs
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         WalkReg_Reset <= 1'b0;
         Ped_Busy      <= 1'b0;
         Ped_Done      <= 1'b0;
         Walk_Lamp     <= 1'b0;
         DontWalk_Lamp <= 1'b1;
      end else begin
         WalkReg_Reset <= wrr_nxt;
         Ped_Busy      <= busy_nxt;
         Ped_Done      <= done_nxt;
         Walk_Lamp     <= walk_nxt;
         DontWalk_Lamp <= dw_nxt;
      end
   end

`ifdef WALK_COUNTDOWN_EN
   // remaining FLASH ticks, zero outside FLASH
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         Countdown <= '0;
      end else begin
         Countdown <= cd_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_walk_phase_ctrl.sv
// Randomized bench for walk_phase_ctrl against a tick-count reference model.
// Drives a modelled walk-request latch, random windows, ticks and resets.
module tb_walk_phase_ctrl;

   localparam int W     = 8;
   localparam int F     = 6;
   localparam int C     = 2;
   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic Reset_n;
   logic Tick;
   logic WalkReq;
   logic Ped_Window;
   logic WalkReg_Reset;
   logic Ped_Busy;
   logic Ped_Done;
   logic Walk_Lamp;
   logic DontWalk_Lamp;
`ifdef WALK_COUNTDOWN_EN
   logic [CNT_W-1:0] Countdown;
`endif

   walk_phase_ctrl #(
      .WALK_TIME  (W),
      .FLASH_TIME (F),
      .CLEAR_TIME (C),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .Reset_n       (Reset_n),
      .Tick          (Tick),
      .WalkReq       (WalkReq),
      .Ped_Window    (Ped_Window),
      .WalkReg_Reset (WalkReg_Reset),
      .Ped_Busy      (Ped_Busy),
      .Ped_Done      (Ped_Done),
      .Walk_Lamp     (Walk_Lamp),
`ifdef WALK_COUNTDOWN_EN
      .DontWalk_Lamp (DontWalk_Lamp),
      .Countdown     (Countdown)
`else
      .DontWalk_Lamp (DontWalk_Lamp)
`endif
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model: mode 0 idle, 1 ack, 2 running; m_t = ticks seen since ACK
   int m_mode = 0;
   int m_t    = 0;
   bit m_done = 1'b0;
   bit m_rst  = 1'b0;
   bit req_l  = 1'b0;
   int n_phase = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_t    = 0;
      m_done = 1'b0;
      m_rst  = 1'b0;
   endtask

   task automatic model_step(input bit tk, input bit req, input bit win);
      m_done = 1'b0;
      m_rst  = 1'b0;
      case (m_mode)
         0: begin
            if (req && win) begin
               m_mode = 1;
               m_rst  = 1'b1;
            end
         end
         1: begin
            m_mode = 2;
            m_t    = 0;
         end
         default: begin
            if (tk) begin
               m_t++;
               if (m_t == W + F + C) begin
                  m_mode = 0;
                  m_done = 1'b1;
                  n_phase++;
               end
            end
         end
      endcase
   endtask

   task automatic check_all();
      bit e_walk;
      bit e_dw;
      bit e_busy;
      int e_cd;
      e_busy = (m_mode != 0);
      e_walk = 1'b0;
      e_dw   = 1'b1;
      e_cd   = 0;
      if (m_mode == 2) begin
         if (m_t < W) begin
            e_walk = 1'b1;
            e_dw   = 1'b0;
         end else if (m_t < W + F) begin
            e_dw = ((m_t - W) % 2 == 0);
            e_cd = W + F - m_t;
         end
      end
      check("WalkReg_Reset", 32'(WalkReg_Reset), 32'(m_rst));
      check("Ped_Busy", 32'(Ped_Busy), 32'(e_busy));
      check("Ped_Done", 32'(Ped_Done), 32'(m_done));
      check("Walk_Lamp", 32'(Walk_Lamp), 32'(e_walk));
      check("DontWalk_Lamp", 32'(DontWalk_Lamp), 32'(e_dw));
      check("lamps_both_on", 32'(Walk_Lamp & DontWalk_Lamp), 32'd0);
`ifdef WALK_COUNTDOWN_EN
      check("Countdown", 32'(Countdown), 32'(e_cd));
`else
      if (e_cd < 0) check("countdown_range", 32'(e_cd), 32'd0);
`endif
   endtask

   task automatic cycle(input bit tk, input bit win, input bit press);
      @(negedge clk);
      if (m_rst) req_l = 1'b0;
      if (press) req_l = 1'b1;
      Tick       = tk;
      WalkReq    = req_l;
      Ped_Window = win;
      @(posedge clk);
      model_step(tk, req_l, win);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      Reset_n    = 1'b0;
      Tick       = 1'b0;
      Ped_Window = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      Reset_n = 1'b1;
   endtask

   initial begin
      Reset_n    = 1'b1;
      Tick       = 1'b0;
      WalkReq    = 1'b0;
      Ped_Window = 1'b0;
      #2;
      Reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;

      // full phase with a tick every cycle, request and window together
      cycle(1'b1, 1'b1, 1'b1);
      repeat (24) cycle(1'b1, 1'b1, 1'b0);
      check("first_phase_done", 32'(n_phase), 32'd1);

      // pending request without a window is never served
      repeat (30) cycle(1'b1, 1'b0, 1'b1);

      // window dropped during WALK; phase still completes
      cycle(1'b0, 1'b1, 1'b0);
      repeat (4) cycle(1'b1, 1'b0, 1'b0);
      repeat (20) cycle(1'b1, 1'b0, 1'b0);
      check("second_phase_done", 32'(n_phase), 32'd2);

      // reset mid-WALK with a pending request
      cycle(1'b0, 1'b1, 1'b1);
      repeat (4) cycle(1'b1, 1'b0, 1'b1);
      do_reset();
      repeat (5) cycle(1'b1, 1'b0, 1'b0);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 15) == 0);
         end
      end
      if (n_phase < 5) check("phase_count_low", 32'(n_phase), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/walk_phase_ctrl.md
Name: walk_phase_ctrl

Overview:
- Consumer side of the pedestrian walk-request latch. Reads the latched WalkReq level and, once the main controller grants an all-red window, issues a one-cycle WalkReg_Reset pulse to clear the latch.
- Then sequences the pedestrian lamps: WALK, then flashing DON'T WALK, then clearance.
- Sits between the walk-request register and the main traffic-light FSM. It holds that FSM in all-red via Ped_Busy until the crossing has cleared.

Parameters:
- WALK_TIME, 8, ticks of steady WALK (0 treated as 1)
- FLASH_TIME, 6, ticks of flashing DON'T WALK (0 treated as 1)
- CLEAR_TIME, 2, ticks of steady DON'T WALK before releasing the main FSM (0 treated as 1)
- CNT_W, 8, width of the phase tick counter; all *_TIME values must be less than 2^CNT_W

Ports:
- clk  input  1  system clock, all state updates on rising edge
- Reset_n  input  1  asynchronous, active-low reset
- Tick  input  1  one-cycle timebase enable (e.g. 1 Hz strobe) from the prescaler
- WalkReq  input  1  latched pedestrian request level from the walk-request register
- Ped_Window  input  1  main FSM: vehicle heads are red, pedestrian phase may start
- WalkReg_Reset  output  1  one-cycle pulse that clears the walk-request register
- Ped_Busy  output  1  pedestrian phase in progress; main FSM must hold all-red
- Ped_Done  output  1  one-cycle pulse at the end of the pedestrian phase
- Walk_Lamp  output  1  WALK lamp drive
- DontWalk_Lamp  output  1  DON'T WALK lamp drive

Behaviour:
- All outputs are registered. Reset (Reset_n=0, async) forces:
  - state IDLE, counter 0, blink phase 0
  - WalkReg_Reset=0, Ped_Busy=0, Ped_Done=0, Walk_Lamp=0, DontWalk_Lamp=1
- States: IDLE, ACK, WALK, FLASH, CLEAR.
- IDLE:
  - DontWalk_Lamp=1, Walk_Lamp=0, Ped_Busy=0.
  - If WalkReq=1 and Ped_Window=1 on a rising edge, go to ACK.
  - WalkReq without Ped_Window waits indefinitely.
- ACK (exactly one cycle):
  - WalkReg_Reset=1, Ped_Busy=1.
  - Load counter with WALK_TIME; next state WALK.
  - A Tick arriving in ACK is ignored.
- WALK:
  - Walk_Lamp=1, DontWalk_Lamp=0.
  - Each Tick decrements the counter. On a Tick with counter==1, load FLASH_TIME, clear blink phase, go to FLASH.
- FLASH:
  - Walk_Lamp=0. DontWalk_Lamp = ~blink phase, so it starts lit.
  - Blink phase toggles on every Tick.
  - On a Tick with counter==1, load CLEAR_TIME and go to CLEAR.
- CLEAR:
  - DontWalk_Lamp=1 steady.
  - On a Tick with counter==1, go to IDLE. Ped_Done=1 and Ped_Busy=0 in the first IDLE cycle.
- Ped_Busy is 1 from ACK through CLEAR inclusive, and asserts the cycle after the accepting edge.
- WalkReg_Reset and Ped_Done are never high together and are never high for more than one cycle.
- Ped_Window deasserting after ACK is ignored; the phase always completes.
- A new WalkReq latched during WALK/FLASH/CLEAR is not cleared. It is served at the next Ped_Window after return to IDLE; it is never served back-to-back within the same phase.
- WalkReq and Ped_Window rising in the same cycle is accepted on that edge.
- Walk_Lamp and DontWalk_Lamp are never both 1. In no state after reset are they both 0, except FLASH off-phase.
- Counter never underflows: it is only decremented when nonzero.
- Any Reset_n assertion mid-phase aborts to IDLE immediately. The request latch is not pulsed, so a pending request survives the reset.

Optional Feature:
- Macro: WALK_COUNTDOWN_EN.
- Defined: adds output port Countdown [CNT_W-1:0].
  - Equals the remaining tick count during FLASH, 0 in all other states.
  - Registered; reset value 0.
- Undefined: port absent; behaviour otherwise identical.

Test Plan:
- Reset sequence: Reset_n=0 mid-WALK -> immediately Walk_Lamp=0, DontWalk_Lamp=1, Ped_Busy=0, WalkReg_Reset=0; after release, stays IDLE.
- Request without window: WalkReq=1, Ped_Window=0 for 20 Ticks -> no WalkReg_Reset, Ped_Busy=0, lamps DON'T WALK.
- Full phase with defaults: WalkReq=1, Ped_Window=1 ->
  - WalkReg_Reset pulses exactly 1 cycle.
  - Walk_Lamp=1 for 8 Ticks.
  - DontWalk_Lamp pattern 1,0,1,0,1,0 over 6 Ticks.
  - 2 Ticks steady DON'T WALK.
  - Ped_Done pulses once; Ped_Busy high throughout.
- Window dropped mid-phase: Ped_Window 1->0 during WALK tick 3 -> phase completes unchanged (total 16 Ticks after ACK), Ped_Busy stays 1.
- Request during service: WalkReq re-asserted during FLASH -> no second WalkReg_Reset until after Ped_Done and a new Ped_Window; then a second full phase.
- WALK_TIME=0 override: -> WALK lasts exactly 1 Tick. With WALK_COUNTDOWN_EN defined, Countdown reads 6,5,4,3,2,1 across FLASH, then 0.
